// File: rtl/serial_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    // Bits needed to count steps 0..w-1 (w >= 2).
    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

    localparam int DEF_WIDTH = 8;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder. OVF exists only with SERIAL_ADDER_OVF_EN.
interface serial_adder_if #(parameter int WIDTH = 8);
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] SUM;
    logic             COUT;
`ifdef SERIAL_ADDER_OVF_EN
    logic             OVF;

    modport master (output START, A, B, CIN, input BUSY, DONE, SUM, COUT, OVF);
    modport slave  (input START, A, B, CIN, output BUSY, DONE, SUM, COUT, OVF);
`else
    modport master (output START, A, B, CIN, input BUSY, DONE, SUM, COUT);
    modport slave  (input START, A, B, CIN, output BUSY, DONE, SUM, COUT);
`endif
endinterface

// File: rtl/serial_adder_fa_bit.sv
// One-bit combinational full adder cell.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, WIDTH steps per addition.
// Optional signed-overflow flag enabled by SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          CLK,
    input  logic          RST,
    serial_adder_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum_sr;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_ovf;
`endif

    logic             w_s;
    logic             w_co;
    logic             w_load;
    logic [WIDTH-1:0] w_sum_next;

    fa_bit u_fa (
        .a  (r_a[0]),
        .b  (r_b[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    // A new request is only accepted when no step is in flight.
    assign w_load     = bus.START && (r_state == IDLE || r_state == FIN);
    assign w_sum_next = {w_s, r_sum_sr[WIDTH-1:1]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else if (w_load) begin
            r_state  <= SHIFT;
            r_a      <= bus.A;
            r_b      <= bus.B;
            r_carry  <= bus.CIN;
            r_cnt    <= '0;
            r_sum_sr <= '0;
        end else begin
            case (r_state)
                SHIFT: begin
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_carry  <= w_co;
                    r_sum_sr <= w_sum_next;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= FIN;
                        r_sum   <= w_sum_next;
                        r_cout  <= w_co;
`ifdef SERIAL_ADDER_OVF_EN
                        // On the last step r_carry is the carry into the MSB.
                        r_ovf   <= r_carry ^ w_co;
`endif
                    end
                end
                FIN:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.BUSY = (r_state == SHIFT);
    assign bus.DONE = (r_state == FIN);
    assign bus.SUM  = r_sum;
    assign bus.COUT = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.OVF  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: expected results queued at issue, checked on DONE.
module tb_serial_adder;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];

    serial_adder_if #(.WIDTH(W)) intf ();

    serial_adder #(.WIDTH(W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (intf.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer addition, overflow from operand/result signs.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input int t0);
        exp_t e;
        logic [W:0] full;
        full       = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        e.sum      = full[W-1:0];
        e.cout     = full[W];
        e.ovf      = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
        e.done_cyc = t0 + W;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && intf.DONE) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: DONE=1 with no pending op (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", cyc, e.done_cyc);
                check("sum", {24'd0, intf.SUM}, {24'd0, e.sum});
                check("cout", {31'd0, intf.COUT}, {31'd0, e.cout});
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf", {31'd0, intf.OVF}, {31'd0, e.ovf});
`endif
            end
        end
    end

    // Called at a negedge; the next posedge is the accepting edge t0.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        intf.START = 1'b1;
        intf.A     = a;
        intf.B     = b;
        intf.CIN   = cin;
        sb.push_back(model(a, b, cin, cyc + 1));
    endtask

    // Full operation with random noise on START/A/B/CIN during the SHIFT steps.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        issue(a, b, cin);
        @(negedge clk);
        for (int i = 0; i < W; i++) begin
            check("busy_shift", {31'd0, intf.BUSY}, 32'd1);
            intf.START = 1'($urandom_range(0, 1));
            intf.A     = W'($urandom);
            intf.B     = W'($urandom);
            intf.CIN   = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        intf.START = 1'b0;
        check("busy_fin", {31'd0, intf.BUSY}, 32'd0);
        @(negedge clk);
        check("done_idle", {31'd0, intf.DONE}, 32'd0);
        check("busy_idle", {31'd0, intf.BUSY}, 32'd0);
    endtask

    initial begin
        intf.START = 1'b0;
        intf.A     = '0;
        intf.B     = '0;
        intf.CIN   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, intf.BUSY}, 32'd0);
        check("rst_done", {31'd0, intf.DONE}, 32'd0);
        check("rst_sum", {24'd0, intf.SUM}, 32'd0);
        check("rst_cout", {31'd0, intf.COUT}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", {31'd0, intf.OVF}, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        run_op(8'h3C, 8'h5A, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0);
        run_op(8'hFF, 8'h00, 1'b1);
        run_op(8'h7F, 8'h01, 1'b0);
        run_op(8'h80, 8'h80, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0);

        // START retrigger with a different operand mid-operation is ignored.
        issue(8'h3C, 8'h5A, 1'b0);
        @(negedge clk);
        intf.START = 1'b0;
        repeat (2) @(negedge clk);
        intf.START = 1'b1;
        intf.A     = 8'h11;
        @(negedge clk);
        intf.START = 1'b0;
        repeat (W - 2) @(negedge clk);
        @(negedge clk);

        // Reset mid-operation aborts: no DONE, outputs cleared.
        issue(8'h3C, 8'h5A, 1'b0);
        @(negedge clk);
        intf.START = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'd0, intf.BUSY}, 32'd0);
        check("abort_done", {31'd0, intf.DONE}, 32'd0);
        check("abort_sum", {24'd0, intf.SUM}, 32'd0);
        check("abort_cout", {31'd0, intf.COUT}, 32'd0);
        repeat (W + 2) @(negedge clk);
        run_op(8'h01, 8'h02, 1'b0);

        // START held high: second op accepted on the FIN cycle.
        issue(8'h10, 8'h20, 1'b0);
        @(negedge clk);
        intf.A = 8'h0F;
        intf.B = 8'h01;
        for (int i = 0; i < W; i++) begin
            check("b2b_busy1", {31'd0, intf.BUSY}, 32'd1);
            @(negedge clk);
        end
        check("b2b_fin", {31'd0, intf.BUSY}, 32'd0);
        sb.push_back(model(8'h0F, 8'h01, 1'b0, cyc + 1));
        @(negedge clk);
        for (int i = 0; i < W; i++) begin
            check("b2b_busy2", {31'd0, intf.BUSY}, 32'd1);
            @(negedge clk);
        end
        intf.START = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 30; n++)
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));

        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial multi-bit adder for the datapath lab set. It loads two WIDTH-bit operands and a carry-in, then adds one bit per clock, LSB first, through a single one-bit full-adder cell with a registered carry. The result is presented as a parallel word with a one-cycle completion pulse. It sits between the operand registers upstream and the result/flag consumers downstream, and trades latency for area against a ripple adder.

## Interface
Parameters:
- WIDTH, default 8: operand and sum width in bits; must be ≥ 2.

Ports:
- CLK  input  1  sole clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
- START  input  1  request a new addition; sampled only when not BUSY.
- A  input  WIDTH  operand A; captured on the accepting edge.
- B  input  WIDTH  operand B; captured on the accepting edge.
- CIN  input  1  carry-in; captured on the accepting edge.
- BUSY  output  1  high while bit steps are in progress.
- DONE  output  1  one-cycle pulse; SUM/COUT are final.
- SUM  output  WIDTH  result word; holds its value until the next completion.
- COUT  output  1  carry out of the MSB; holds like SUM.

## Operation
- State machine with three states:
  - IDLE to SHIFT on START, which loads the shift registers a_sr←A, b_sr←B, carry←CIN, cnt←0 and clears the internal sum_sr.
  - SHIFT to SHIFT while cnt < WIDTH−1.
  - SHIFT to FIN on the step where cnt = WIDTH−1.
  - FIN to IDLE, or FIN to SHIFT if START is high (back-to-back, same load action).
- Each SHIFT step:
  - s = a_sr[0]^b_sr[0]^carry.
  - carry ← majority(a_sr[0], b_sr[0], carry).
  - a_sr and b_sr shift right by one.
  - s shifts into sum_sr from the MSB side.
  - cnt increments.
- The last step also loads SUM ← final sum_sr and COUT ← final carry. Both are registered.
- Arithmetic is unsigned modulo 2^WIDTH. The carry out is COUT.
- START is ignored while in SHIFT: no restart, and operands are not re-sampled. A/B/CIN may change freely after the accepting edge.
- BUSY = (state == SHIFT). DONE = (state == FIN).
- Reset values: state IDLE, BUSY 0, DONE 0, SUM 0, COUT 0, cnt 0, carry 0.
- RST during SHIFT aborts the operation. No DONE is produced, and SUM/COUT return to 0.
- RST has priority over START on the same edge.

## Timing
- Let edge t0 be the edge that samples START=1 while in IDLE or FIN.
- BUSY is high from t0 to t0+WIDTH.
- SUM and COUT update at edge t0+WIDTH.
- DONE is high from t0+WIDTH to t0+WIDTH+1, exactly one cycle.
- Latency is WIDTH+1 cycles from START to the end of the DONE pulse.
- Throughput is one addition per WIDTH+1 cycles when START is held high continuously; a new operation is accepted on the FIN cycle.
- No combinational path from inputs to outputs.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - Adds output port OVF (1 bit, reset 0), the two's-complement signed overflow flag.
  - OVF = carry into MSB XOR carry out of MSB, captured on the final step.
  - OVF updates and holds exactly like COUT.
- SERIAL_ADDER_OVF_EN undefined:
  - The OVF port and its logic are absent.
  - All other behaviour is identical.

## Structure
- Shared package serial_pkg holds:
  - the state enum (IDLE, SHIFT, FIN);
  - localparam helper CNT_W = $clog2(WIDTH).
- One sub-module, fa_bit: purely combinational one-bit full adder with inputs a, b, ci and outputs s, co. It is instantiated once; the carry register lives in serial_adder.

## Test plan
- WIDTH=8, A=0x3C, B=0x5A, CIN=0 → after 8 steps SUM=0x96, COUT=0. DONE pulses exactly once, 9 cycles after START.
- A=0xFF, B=0x01, CIN=0 → SUM=0x00, COUT=1. Then A=0xFF, B=0x00, CIN=1 → SUM=0x00, COUT=1.
- START pulsed again at step 3 with A=0x11 → ignored, result is still that of the first operands. Operand inputs changed after t0 have no effect.
- RST asserted at step 4 of 0x3C+0x5A → next cycle BUSY=0, SUM=0, COUT=0, no DONE. A subsequent 0x01+0x02 gives SUM=0x03.
- START held high across two operations (0x10+0x20, then 0x0F+0x01) → DONE pulses at t0+8 and t0+17, with SUM=0x30 then SUM=0x10. BUSY is low only during the FIN cycles.
- With SERIAL_ADDER_OVF_EN: 0x7F+0x01 → SUM=0x80, COUT=0, OVF=1. 0x80+0x80 → SUM=0x00, COUT=1, OVF=1. 0xFF+0x01 → OVF=0.
